// File: rtl/display_scan_ctrl.sv
// Signed 32-bit to 10-digit BCD converter (double-dabble) feeding a
// multiplexed, leading-zero-blanked 10-position display scanner.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  digit,
  output logic [9:0]  an,
  output logic        blank,
  output logic        neg
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t      state;
  logic [31:0] mag;
  logic        sign;
  logic        mag_nz;
  logic [39:0] bcd;
  logic [4:0]  iter;

  logic [39:0] disp;
  logic        disp_sign;

  logic [CW-1:0] pre_cnt;
  logic          tick;
  logic [3:0]    idx;
  logic [3:0]    idx_next;
  logic [3:0]    hi_pos;
  logic [39:0]   bcd_adj;

  // Double-dabble correction: any nibble >= 5 would overflow past 9 when doubled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // The shifted magnitude is destroyed by conversion, so zero-ness is kept aside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      mag       <= '0;
      sign      <= 1'b0;
      mag_nz    <= 1'b0;
      bcd       <= '0;
      iter      <= '0;
      // NOTE: the display register is reset explicitly so a fresh reset always shows 0.
      disp      <= '0;
      disp_sign <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // sample pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (load) begin
            mag    <= value_in[31] ? (~value_in + 32'd1) : value_in;
            sign   <= value_in[31];
            mag_nz <= (value_in != 32'd0);
            bcd    <= '0;
            iter   <= '0;
            busy   <= 1'b1;
            state  <= CONVERT;
          end else begin
            busy <= 1'b0;
          end
        end
        CONVERT: begin
          bcd  <= {bcd_adj[38:0], mag[31]};
          mag  <= {mag[30:0], 1'b0};
          iter <= iter + 5'd1;
          busy <= 1'b1;
          if (iter == 5'd31) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          disp      <= bcd;
          disp_sign <= sign & mag_nz;
          busy      <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign tick     = (pre_cnt == DIV_LAST);
  assign idx_next = tick ? ((idx == 4'd9) ? 4'd0 : idx + 4'd1) : idx;

  // Highest nonzero display position; position 0 is the floor so 0 shows as "0".
  always_comb begin
    hi_pos = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (disp[4*i +: 4] != 4'd0) begin
        hi_pos = 4'(i);
      end
    end
  end

  // Scan outputs are registered alongside the index they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      idx     <= 4'd0;
      an      <= 10'b1111111110;
      digit   <= 4'd0;
      blank   <= 1'b0;
      neg     <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      idx     <= idx_next;
      an      <= ~(10'd1 << idx_next);
      digit   <= disp[4*idx_next +: 4];
      blank   <= (idx_next > hi_pos);
      neg     <= disp_sign;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed and random loads compared every cycle
// against a decimal-arithmetic model of the displayed value and scan position.
module tb_display_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value_in;
  logic        load;
  logic        busy;
  logic [3:0]  digit;
  logic [9:0]  an;
  logic        blank;
  logic        neg;

  int errors = 0;
  int checks = 0;

  int     k;           // edges since reset release
  int     ce;          // edges since accepted load, -1 when no conversion pending
  longint shown_mag;
  bit     shown_neg;
  longint pend_mag;
  bit     pend_neg;

  always #5 clk = ~clk;

  display_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .load     (load),
    .busy     (busy),
    .digit    (digit),
    .an       (an),
    .blank    (blank),
    .neg      (neg)
  );

  function automatic longint abs_of(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [3:0] digit_at(input longint m, input int p);
    longint r;
    r = m;
    for (int i = 0; i < p; i++) r = r / 10;
    return 4'(r % 10);
  endfunction

  function automatic int top_pos(input longint m);
    int h;
    h = 0;
    for (int p = 0; p < 10; p++) if (digit_at(m, p) != 4'd0) h = p;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // One clock edge: advance the model, then compare every output.
  task automatic step();
    bit          lv;
    logic [31:0] vv;
    bit          idle;
    int          pos;
    logic [9:0]  exp_an;
    lv = load;
    vv = value_in;
    @(posedge clk);
    #1;
    k++;
    idle = (ce == -1) || (ce == 33);
    if (ce >= 0) ce++;
    if (ce == 34) begin
      shown_mag = pend_mag;
      shown_neg = pend_neg;
      ce = -1;
    end
    if (idle && lv) begin
      pend_mag = abs_of(vv);
      pend_neg = vv[31] && (vv != 32'd0);
      ce = 0;
    end
    pos    = (k / DIV) % 10;
    exp_an = ~(10'd1 << pos);
    chk("busy",  32'(busy),  32'(ce != -1));
    chk("an",    32'(an),    32'(exp_an));
    chk("digit", 32'(digit), 32'(digit_at(shown_mag, pos)));
    chk("blank", 32'(blank), 32'(pos > top_pos(shown_mag)));
    chk("neg",   32'(neg),   32'(shown_neg));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_val(input logic [31:0] v);
    value_in = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Asynchronous reset, checked while held, released before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    ce = -1;
    shown_mag = 0;
    shown_neg = 1'b0;
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_an",    32'(an),    32'h3FE);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_neg",   32'(neg),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    value_in = '0;
    k = 0;
    ce = -1;
    shown_mag = 0;
    shown_neg = 1'b0;
    pend_mag = 0;
    pend_neg = 1'b0;
    #1;
    do_reset();
    run(3);

    // 12345: busy for 34 edges, then digits 5,4,3,2,1 with upper positions blank
    load_val(32'd12345);
    run(34 + 10 * DIV);

    // -7: single digit, negative sign
    load_val(-32'sd7);
    run(34 + 10 * DIV);

    // most negative value uses all ten digits
    load_val(32'h8000_0000);
    run(34 + 10 * DIV);

    // -5 then 0: sign must clear, single "0" shown
    load_val(-32'sd5);
    run(34);
    load_val(32'd0);
    run(34 + 10 * DIV);

    // 99, then 55 while busy: 55 is dropped
    load_val(32'd99);
    run(9);
    load_val(32'd55);
    run(30 + 20 * DIV);

    // load held high: back-to-back conversions on the first idle cycle
    value_in = 32'd4321;
    load = 1'b1;
    run(40);
    value_in = -32'sd678;
    run(40);
    load = 1'b0;
    run(34 + 10 * DIV);

    // random values, including the occasional extreme
    for (int i = 0; i < 8; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (i == 3) r = 32'h7FFF_FFFF;
      if (i == 5) r = r >> $urandom_range(31, 0);
      load_val(r);
      run(34 + 10 * DIV);
    end

    // reset at cycle 20 of converting 321: no commit, scan restarts from position 0
    load_val(32'd321);
    run(19);
    do_reset();
    run(10 * DIV + 4);

    // first load after reset release is accepted on the first low-reset edge
    do_reset();
    load_val(32'd8);
    run(34 + 10 * DIV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
